// File: rtl/dmem_responder.sv
// Data-memory slave for the core's load/store port: one request at a time, fixed extra
// latency, RV32I lane selection / extension, and alignment, range and funct3 checking.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] MemBytes = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]     off;
  logic [IdxW-1:0] idx;
  logic [1:0]      lane;
  logic            range_err;
  logic            funct3_err;
  logic            align_err;
  logic            err;
  logic [31:0]     word;
  logic [31:0]     shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_data;
  logic [3:0]      be;
  logic [31:0]     wdata_lane;
  logic            commit;

  // Decode is done entirely from the latched request so input changes after acceptance are inert.
  always_comb begin
    off       = addr_q - BASE_ADDR;
    idx       = off[IdxW+1:2];
    lane      = off[1:0];
    range_err = (off >= MemBytes);

    if (we_q) funct3_err = (funct3_q > 3'd2);
    else      funct3_err = (funct3_q == 3'd3) || (funct3_q[2:1] == 2'b11);

    unique case (funct3_q[1:0])
      2'b01:   align_err = off[0];
      2'b10:   align_err = (off[1:0] != 2'b00);
      default: align_err = 1'b0;
    endcase

    err      = range_err || funct3_err || align_err;
    word     = mem[idx];
    shifted  = word >> {lane, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = off[1] ? word[31:16] : word[15:0];

    case (funct3_q)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_data = word;
      3'd4:    load_data = {24'h0, byte_sel};
      3'd5:    load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase

    case (funct3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata_q;
      end
    endcase

    commit = (state_q == StWait) && (cnt_q == 4'd0);
  end

  // Storage is never reset; an async reset drops state_q and so kills a pending commit.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      funct3_q    <= 3'd0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            funct3_q    <= req_funct3;
            wdata_q     <= req_wdata;
            cnt_q       <= 4'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (we_q || err) ? 32'h0 : load_data;
            rsp_err_q   <= err;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait cycles, one with zero latency.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_funct3;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [2:0]  z_req_funct3;

  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_zero (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we), .req_addr(z_req_addr),
    .req_funct3(z_req_funct3), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err)
  );

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Zero-latency monitor: edge numbers of acceptances and rsp_valid rises.
  int unsigned z_acc[$];
  int unsigned z_rise[$];
  logic [31:0] z_data[$];
  logic        z_prev = 1'b0;
  always @(negedge clk) begin
    if (z_req_valid && z_req_ready) z_acc.push_back(edge_cnt + 1);
    if (z_rsp_valid && !z_prev) begin
      z_rise.push_back(edge_cnt);
      z_data.push_back(z_rsp_rdata);
    end
    z_prev = z_rsp_valid;
  end

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int          t;
    int unsigned acc;
    logic [31:0] rd;
    logic        er;
    t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!req_ready) check_val({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wdata;
    rsp_ready  = (hold == 0);
    @(posedge clk); #1;
    acc        = edge_cnt;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_addr   = 32'hFFFF_FFFC;
    req_funct3 = 3'd7;
    req_wdata  = 32'h5A5A_5A5A;
    check_val({tag, "_ready_fall"}, 32'(req_ready), 32'd0);
    t = 0;
    while (!rsp_valid && t < 40) begin
      @(posedge clk); #1; t++;
    end
    check_val({tag, "_latency"}, 32'(edge_cnt - acc), 32'd3);
    check_val({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check_val({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
      check_val({tag, "_bp_rdata"}, rsp_rdata, rd);
      check_val({tag, "_bp_err"}, 32'(rsp_err), 32'(er));
      check_val({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_val({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    check_val({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_funct3 = '0; z_req_wdata = '0;
    z_rsp_ready = 1'b1;
    #1;
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    check_val("rst_ready_held", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check_val("first_edge_ready", 32'(req_ready), 32'd1);

    // Word round-trip
    xact("sw_10", 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    xact("lw_10", 1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Byte and half lanes
    xact("sw_20", 1'b1, 32'h20, 3'd2, 32'h0000_0000, 32'h0, 1'b0, 0);
    xact("sb_23", 1'b1, 32'h23, 3'd0, 32'hFFFF_FF80, 32'h0, 1'b0, 0);
    xact("lw_20a", 1'b0, 32'h20, 3'd2, 32'h0, 32'h8000_0000, 1'b0, 0);
    xact("lb_23", 1'b0, 32'h23, 3'd0, 32'h0, 32'hFFFF_FF80, 1'b0, 0);
    xact("lbu_23", 1'b0, 32'h23, 3'd4, 32'h0, 32'h0000_0080, 1'b0, 0);
    xact("sh_20", 1'b1, 32'h20, 3'd1, 32'hABCD_1234, 32'h0, 1'b0, 0);
    xact("lw_20b", 1'b0, 32'h20, 3'd2, 32'h0, 32'h8000_1234, 1'b0, 0);
    xact("lh_22", 1'b0, 32'h22, 3'd1, 32'h0, 32'hFFFF_8000, 1'b0, 0);
    xact("lhu_22", 1'b0, 32'h22, 3'd5, 32'h0, 32'h0000_8000, 1'b0, 0);

    // Errors
    xact("lw_mis", 1'b0, 32'h22, 3'd2, 32'h0, 32'h0, 1'b1, 0);
    xact("sh_mis", 1'b1, 32'h21, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    xact("lw_20c", 1'b0, 32'h20, 3'd2, 32'h0, 32'h8000_1234, 1'b0, 0);
    xact("lw_range", 1'b0, 32'h400, 3'd2, 32'h0, 32'h0, 1'b1, 0);
    xact("lw_last", 1'b0, 32'h3FC, 3'd2, 32'h0, 32'h0, 1'b0, 0);
    xact("ld_f3_3", 1'b0, 32'h20, 3'd3, 32'h0, 32'h0, 1'b1, 0);
    xact("sw_f3_4", 1'b1, 32'h20, 3'd4, 32'h0, 32'h0, 1'b1, 0);
    xact("lw_20d", 1'b0, 32'h20, 3'd2, 32'h0, 32'h8000_1234, 1'b0, 0);

    // Back-pressure
    xact("lw_bp", 1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);

    // Reset mid-WAIT
    xact("sw_40a", 1'b1, 32'h40, 3'd2, 32'h1111_1111, 32'h0, 1'b0, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_funct3 = 3'd2;
    req_wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("midrst_accepted", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_val("midrst_req_ready", 32'(req_ready), 32'd0);
    check_val("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("midrst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("midrst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    xact("lw_40", 1'b0, 32'h40, 3'd2, 32'h0, 32'h1111_1111, 1'b0, 0);

    // Zero latency, back-to-back
    for (int i = 0; i < 4; i++) begin
      int t;
      t = 0;
      while (!z_req_ready && t < 20) begin
        @(posedge clk); #1; t++;
      end
      z_req_valid  = 1'b1;
      z_req_we     = (i == 0);
      z_req_addr   = 32'h8;
      z_req_funct3 = 3'd2;
      z_req_wdata  = 32'hCAFE_F00D;
      @(posedge clk); #1;
      z_req_valid  = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    check_val("z_acc_count", 32'(z_acc.size()), 32'd4);
    check_val("z_rise_count", 32'(z_rise.size()), 32'd4);
    for (int i = 0; i < z_acc.size() && i < z_rise.size(); i++)
      check_val("z_latency", 32'(z_rise[i] - z_acc[i]), 32'd1);
    for (int i = 0; i + 1 < z_acc.size(); i++)
      check_val("z_spacing", 32'(z_acc[i+1] - z_acc[i]), 32'd3);
    for (int i = 1; i < z_data.size(); i++)
      check_val("z_rdata", z_data[i], 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
